// File: rtl/big_core_cr_bank.sv
// ---------------------------------------------------------------------------
// big_core_cr_bank
//
// Parametrised control-register bank for big_core. It has four address
// regions, each holding up to 2**IDX_W words:
//   region 0 : NUM_RW read/write registers, reflected onto rw_out
//   region 1 : NUM_RO read-only registers, sampled from ro_in
//   region 2 : sticky event status, write-1-to-clear (index 0 only)
//   region 3 : event interrupt mask (index 0 only)
// Two ports (A = core, B = fabric) can both read and write. Writes use byte
// enables. Reads return data one cycle after rden, and the value is the
// register state from before any write in the same cycle.
//
// Ports
//   Clk, Rst_N          clock, asynchronous active-low reset
//   address/data/byteen/wren/rden, q
//                       port A byte address, write data, byte enables,
//                       write strobe, read strobe, registered read data
//   address_b/data_b/byteen_b/wren_b/rden_b, q_b
//                       port B, same meaning as port A
//   ro_in               RO register sources, word 0 in the LSBs
//   rw_out              registered copy of the RW registers
//   ro_pop              one-cycle pulse per RO word read by port A
//   evt_in              level event sources
//   irq                 registered interrupt (status & mask)
//   addr_err            one-cycle pulse on an unmapped port A access
//
// Optional build macro: BIG_CORE_CR_RO_SYNC_EN
//   When defined, ro_in and evt_in each pass through a 2-flop synchronizer
//   before they are sampled.
// ---------------------------------------------------------------------------
module big_core_cr_bank #(
  parameter int DATA_W  = 32,
  parameter int NUM_RW  = 8,
  parameter int NUM_RO  = 8,
  parameter int NUM_EVT = 8,
  parameter int IDX_W   = 4,
  parameter int ADDR_W  = 32
) (
  input  logic                       Clk,
  input  logic                       Rst_N,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          data,
  input  logic [DATA_W/8-1:0]        byteen,
  input  logic                       wren,
  input  logic                       rden,
  output logic [DATA_W-1:0]          q,
  input  logic [ADDR_W-1:0]          address_b,
  input  logic [DATA_W-1:0]          data_b,
  input  logic [DATA_W/8-1:0]        byteen_b,
  input  logic                       wren_b,
  input  logic                       rden_b,
  output logic [DATA_W-1:0]          q_b,
  input  logic [NUM_RO*DATA_W-1:0]   ro_in,
  output logic [NUM_RW*DATA_W-1:0]   rw_out,
  output logic [NUM_RO-1:0]          ro_pop,
  input  logic [NUM_EVT-1:0]         evt_in,
  output logic                       irq,
  output logic                       addr_err
);

  localparam int NBYTES = DATA_W / 8;

  localparam logic [1:0] REGION_RW = 2'd0;
  localparam logic [1:0] REGION_RO = 2'd1;
  localparam logic [1:0] REGION_ST = 2'd2;
  localparam logic [1:0] REGION_MK = 2'd3;

  typedef struct packed {
    logic             mapped;
    logic [1:0]       region;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Address decode. The byte offset inside a word is ignored, so address[1:0]
  // is deliberately not looked at.
  function automatic dec_t decode(input logic [ADDR_W-1:0] a);
    dec_t d;
    d.idx    = a[IDX_W+1:2];
    d.region = a[IDX_W+3:IDX_W+2];
    d.mapped = ~|a[ADDR_W-1:IDX_W+4];
    case (d.region)
      REGION_RW: if (int'(d.idx) >= NUM_RW) d.mapped = 1'b0;
      REGION_RO: if (int'(d.idx) >= NUM_RO) d.mapped = 1'b0;
      default:   if (d.idx != '0) d.mapped = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] lanes(input logic [NBYTES-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int k = 0; k < NBYTES; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  // Port A has priority on every lane it enables. Port B only fills in the
  // lanes that A leaves alone.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                               input logic [DATA_W-1:0] da,
                                               input logic [DATA_W-1:0] ma,
                                               input logic [DATA_W-1:0] db,
                                               input logic [DATA_W-1:0] mb);
    return (old & ~(ma | mb)) | (da & ma) | (db & mb & ~ma);
  endfunction

  // State
  logic [DATA_W-1:0]        rw_q [NUM_RW];
  logic [DATA_W-1:0]        rw_d [NUM_RW];
  logic [DATA_W-1:0]        mask_q, mask_d;
  logic [NUM_EVT-1:0]       status_q, status_d;
  logic [NUM_EVT-1:0]       evt_q, evt_hist_q;
  logic [NUM_RO*DATA_W-1:0] ro_q;
  logic [DATA_W-1:0]        q_q, q_b_q;
  logic [NUM_RW*DATA_W-1:0] rw_out_q;
  logic [NUM_RO-1:0]        ro_pop_q, ro_pop_d;
  logic                     irq_q, irq_d;
  logic                     addr_err_q;

  logic [NUM_RO*DATA_W-1:0] ro_src;
  logic [NUM_EVT-1:0]       evt_src;
  logic [NUM_EVT-1:0]       rise;

  dec_t              dec_a, dec_b;
  logic [DATA_W-1:0] lane_a, lane_b;
  logic              wr_rw_a, wr_st_a, wr_mk_a;
  logic              wr_rw_b, wr_st_b, wr_mk_b;
  logic [DATA_W-1:0] clr;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{address[1:0], address_b[1:0]};

  assign dec_a  = decode(address);
  assign dec_b  = decode(address_b);
  assign lane_a = lanes(byteen);
  assign lane_b = lanes(byteen_b);

  // Writes to the RO region fall through every strobe below, so they are
  // silently dropped.
  assign wr_rw_a = wren   && dec_a.mapped && (dec_a.region == REGION_RW);
  assign wr_st_a = wren   && dec_a.mapped && (dec_a.region == REGION_ST);
  assign wr_mk_a = wren   && dec_a.mapped && (dec_a.region == REGION_MK);
  assign wr_rw_b = wren_b && dec_b.mapped && (dec_b.region == REGION_RW);
  assign wr_st_b = wren_b && dec_b.mapped && (dec_b.region == REGION_ST);
  assign wr_mk_b = wren_b && dec_b.mapped && (dec_b.region == REGION_MK);

`ifdef BIG_CORE_CR_RO_SYNC_EN
  // Two-flop synchronizers for asynchronous fabric/peripheral sources.
  logic [NUM_RO*DATA_W-1:0] ro_s1_q, ro_s2_q;
  logic [NUM_EVT-1:0]       evt_s1_q, evt_s2_q;

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      ro_s1_q  <= '0;
      ro_s2_q  <= '0;
      evt_s1_q <= '0;
      evt_s2_q <= '0;
    end else begin
      ro_s1_q  <= ro_in;
      ro_s2_q  <= ro_s1_q;
      evt_s1_q <= evt_in;
      evt_s2_q <= evt_s1_q;
    end
  end

  assign ro_src  = ro_s2_q;
  assign evt_src = evt_s2_q;
`else
  assign ro_src  = ro_in;
  assign evt_src = evt_in;
`endif

  // Edge detection runs on registered event levels, so a rise is seen one
  // cycle after the input changes.
  assign rise = evt_q & ~evt_hist_q;

  // Next state for RW, mask and status. Clears from both ports are ORed
  // together. A new rise is applied after the clear, so a set wins over a
  // clear in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_RW; i++) begin
      rw_d[i] = merge(rw_q[i],
                      data,   (wr_rw_a && int'(dec_a.idx) == i) ? lane_a : '0,
                      data_b, (wr_rw_b && int'(dec_b.idx) == i) ? lane_b : '0);
    end
    mask_d   = merge(mask_q, data, wr_mk_a ? lane_a : '0,
                     data_b, wr_mk_b ? lane_b : '0);
    clr      = (wr_st_a ? (data & lane_a) : '0) | (wr_st_b ? (data_b & lane_b) : '0);
    status_d = (status_q & ~clr[NUM_EVT-1:0]) | rise;
    irq_d    = |(status_d & mask_d[NUM_EVT-1:0]);
  end

  // Read mux on current (pre-write) state. Status bits at or above NUM_EVT
  // read as zero.
  function automatic logic [DATA_W-1:0] rd_value(input dec_t d);
    logic [DATA_W-1:0] v;
    v = '0;
    if (d.mapped) begin
      case (d.region)
        REGION_RW: for (int i = 0; i < NUM_RW; i++) if (int'(d.idx) == i) v = rw_q[i];
        REGION_RO: for (int i = 0; i < NUM_RO; i++) if (int'(d.idx) == i) v = ro_q[i*DATA_W +: DATA_W];
        REGION_ST: v[NUM_EVT-1:0] = status_q;
        default:   v = mask_q;
      endcase
    end
    return v;
  endfunction

  assign rd_a = rd_value(dec_a);
  assign rd_b = rd_value(dec_b);

  // Only port A reads pop an RO word.
  always_comb begin
    ro_pop_d = '0;
    for (int i = 0; i < NUM_RO; i++) begin
      ro_pop_d[i] = rden && dec_a.mapped && (dec_a.region == REGION_RO) && (int'(dec_a.idx) == i);
    end
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= '0;
      mask_q     <= '0;
      status_q   <= '0;
      evt_q      <= '0;
      evt_hist_q <= '0;
      ro_q       <= '0;
      q_q        <= '0;
      q_b_q      <= '0;
      rw_out_q   <= '0;
      ro_pop_q   <= '0;
      irq_q      <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        rw_q[i]                       <= rw_d[i];
        rw_out_q[i*DATA_W +: DATA_W]  <= rw_q[i];
      end
      mask_q     <= mask_d;
      status_q   <= status_d;
      evt_q      <= evt_src;
      evt_hist_q <= evt_q;
      ro_q       <= ro_src;
      q_q        <= rden   ? rd_a : '0;
      q_b_q      <= rden_b ? rd_b : '0;
      ro_pop_q   <= ro_pop_d;
      irq_q      <= irq_d;
      addr_err_q <= (rden || wren) && !dec_a.mapped;
    end
  end

  assign q        = q_q;
  assign q_b      = q_b_q;
  assign rw_out   = rw_out_q;
  assign ro_pop   = ro_pop_q;
  assign irq      = irq_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_big_core_cr_bank.sv
// ---------------------------------------------------------------------------
// tb_big_core_cr_bank
//
// Self-checking bench for big_core_cr_bank in its default build. Stimulus
// tasks push the expected port responses into queues. A monitor pops one
// entry every cycle after a port access and compares it with q/ro_pop/
// addr_err (port A) or q_b (port B). Expected values are hand-computed
// constants.
// ---------------------------------------------------------------------------
module tb_big_core_cr_bank;

  localparam int DATA_W  = 32;
  localparam int NUM_RW  = 8;
  localparam int NUM_RO  = 8;
  localparam int NUM_EVT = 8;
  localparam int IDX_W   = 4;
  localparam int ADDR_W  = 32;

  logic                      Clk = 1'b0;
  logic                      Rst_N = 1'b0;
  logic [ADDR_W-1:0]         address = '0;
  logic [DATA_W-1:0]         data = '0;
  logic [DATA_W/8-1:0]       byteen = '0;
  logic                      wren = 1'b0;
  logic                      rden = 1'b0;
  logic [DATA_W-1:0]         q;
  logic [ADDR_W-1:0]         address_b = '0;
  logic [DATA_W-1:0]         data_b = '0;
  logic [DATA_W/8-1:0]       byteen_b = '0;
  logic                      wren_b = 1'b0;
  logic                      rden_b = 1'b0;
  logic [DATA_W-1:0]         q_b;
  logic [NUM_RO*DATA_W-1:0]  ro_in = '0;
  logic [NUM_RW*DATA_W-1:0]  rw_out;
  logic [NUM_RO-1:0]         ro_pop;
  logic [NUM_EVT-1:0]        evt_in = '0;
  logic                      irq;
  logic                      addr_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] q;
    logic [7:0]  pop;
    logic        err;
  } exp_a_t;

  exp_a_t      expA[$];
  logic [31:0] expB[$];

  big_core_cr_bank #(
    .DATA_W(DATA_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO),
    .NUM_EVT(NUM_EVT), .IDX_W(IDX_W), .ADDR_W(ADDR_W)
  ) dut (
    .Clk(Clk), .Rst_N(Rst_N),
    .address(address), .data(data), .byteen(byteen), .wren(wren), .rden(rden), .q(q),
    .address_b(address_b), .data_b(data_b), .byteen_b(byteen_b),
    .wren_b(wren_b), .rden_b(rden_b), .q_b(q_b),
    .ro_in(ro_in), .rw_out(rw_out), .ro_pop(ro_pop),
    .evt_in(evt_in), .irq(irq), .addr_err(addr_err)
  );

  // 10 ns clock: posedge at 5, 15, ...; negedge at 10, 20, ...
  always #5 Clk = ~Clk;

  // One comparison; mismatches are counted and reported.
  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Drive one cycle of access on both ports (called just after a negedge),
  // push expectations, then release the strobes at the next negedge.
  task automatic applyStimulus(
    input logic [31:0] aAddr, input logic [31:0] aData, input logic [3:0] aBe,
    input logic aWe, input logic aRe,
    input logic [31:0] aExpQ, input logic [7:0] aExpPop, input logic aExpErr,
    input logic [31:0] bAddr, input logic [31:0] bData, input logic [3:0] bBe,
    input logic bWe, input logic bRe, input logic [31:0] bExpQ);
    exp_a_t e;
    address = aAddr; data = aData; byteen = aBe; wren = aWe; rden = aRe;
    address_b = bAddr; data_b = bData; byteen_b = bBe; wren_b = bWe; rden_b = bRe;
    if (aWe || aRe) begin
      e.q = aExpQ; e.pop = aExpPop; e.err = aExpErr;
      expA.push_back(e);
    end
    if (bRe) expB.push_back(bExpQ);
    @(negedge Clk);
    wren = 1'b0; rden = 1'b0; wren_b = 1'b0; rden_b = 1'b0;
  endtask

  task automatic writeA(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic expErr);
    applyStimulus(a, d, be, 1'b1, 1'b0, 32'h0, 8'h0, expErr,
                  32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic readA(input logic [31:0] a, input logic [31:0] expQ,
                       input logic [7:0] expPop, input logic expErr);
    applyStimulus(a, 32'h0, 4'h0, 1'b0, 1'b1, expQ, expPop, expErr,
                  32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic readB(input logic [31:0] a, input logic [31:0] expQ);
    applyStimulus(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 8'h0, 1'b0,
                  a, 32'h0, 4'h0, 1'b0, 1'b1, expQ);
  endtask

  // Monitor: note which ports were active at each posedge, then at the
  // following negedge pop and compare. Idle cycles must show zero outputs.
  initial begin : monitor
    logic        actA, actB;
    exp_a_t      ea;
    logic [31:0] eb;
    forever begin
      @(posedge Clk);
      actA = rden | wren;
      actB = rden_b;
      @(negedge Clk);
      if (actA) begin
        if (expA.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL portA_unexpected actual=access required=queued_expectation");
        end else begin
          ea = expA.pop_front();
          checkOutput("portA_q", q, ea.q);
          checkOutput("portA_ro_pop", ro_pop, ea.pop);
          checkOutput("portA_addr_err", addr_err, ea.err);
        end
      end else begin
        checkOutput("idleA_q", q, 0);
        checkOutput("idleA_ro_pop", ro_pop, 0);
        checkOutput("idleA_addr_err", addr_err, 0);
      end
      if (actB) begin
        if (expB.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL portB_unexpected actual=access required=queued_expectation");
        end else begin
          eb = expB.pop_front();
          checkOutput("portB_q", q_b, eb);
        end
      end else begin
        checkOutput("idleB_q", q_b, 0);
      end
    end
  end

  // Main directed sequence; every step starts just after a negedge.
  initial begin : stimulus
    repeat (2) @(negedge Clk);
    Rst_N = 1'b1;

    // Reset state
    checkOutput("reset_rw_out", rw_out, 0);
    checkOutput("reset_irq", irq, 0);
    checkOutput("reset_q", q, 0);
    readA(32'h00, 32'h0, 8'h0, 1'b0);
    readA(32'h80, 32'h0, 8'h0, 1'b0);

    // Byte enables and rw_out lag
    writeA(32'h0C, 32'h11223344, 4'b1111, 1'b0);
    writeA(32'h0C, 32'hAABBCCDD, 4'b0101, 1'b0);
    checkOutput("rw_out3_lag", rw_out[3*32 +: 32], 32'h11223344);
    @(negedge Clk);
    checkOutput("rw_out3", rw_out[3*32 +: 32], 32'h11BB33DD);
    readA(32'h0C, 32'h11BB33DD, 8'h0, 1'b0);

    // Port collision on RW1
    applyStimulus(32'h04, 32'h000000FF, 4'b0001, 1'b1, 1'b0, 32'h0, 8'h0, 1'b0,
                  32'h04, 32'h12345678, 4'b1111, 1'b1, 1'b0, 32'h0);
    readA(32'h04, 32'h123456FF, 8'h0, 1'b0);
    readB(32'h04, 32'h123456FF);
    // Simultaneous read and write: old data back, new data stored
    applyStimulus(32'h04, 32'hCAFEF00D, 4'b1111, 1'b1, 1'b1, 32'h123456FF, 8'h0, 1'b0,
                  32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0);
    readA(32'h04, 32'hCAFEF00D, 8'h0, 1'b0);

    // Events and irq
    writeA(32'hC0, 32'h01, 4'b1111, 1'b0);
    evt_in = 8'h05;
    @(negedge Clk);
    evt_in = 8'h00;
    checkOutput("irq_not_yet", irq, 1'b0);
    @(negedge Clk);
    checkOutput("irq_two_cycles", irq, 1'b1);
    readA(32'h80, 32'h05, 8'h0, 1'b0);
    readA(32'hC0, 32'h01, 8'h0, 1'b0);
    writeA(32'h80, 32'h01, 4'b1111, 1'b0);
    checkOutput("irq_after_w1c", irq, 1'b0);
    readA(32'h80, 32'h04, 8'h0, 1'b0);
    // Rise of bit 2 lands in the same cycle as its W1C: set wins
    evt_in = 8'h04;
    @(negedge Clk);
    writeA(32'h80, 32'h04, 4'b1111, 1'b0);
    evt_in = 8'h00;
    readA(32'h80, 32'h04, 8'h0, 1'b0);

    // RO pop
    ro_in[2*32 +: 32] = 32'h5A;
    @(negedge Clk);
    readA(32'h48, 32'h5A, 8'h04, 1'b0);
    readB(32'h48, 32'h5A);
    writeA(32'h48, 32'hFFFF_FFFF, 4'b1111, 1'b0);
    readA(32'h48, 32'h5A, 8'h04, 1'b0);
    readA(32'h60, 32'h0, 8'h0, 1'b1);

    // Reset in the middle of operation
    writeA(32'hC0, 32'hFF, 4'b1111, 1'b0);
    checkOutput("irq_mask_all", irq, 1'b1);
    writeA(32'h00, 32'hDEADBEEF, 4'b1111, 1'b0);
    readA(32'h00, 32'hDEADBEEF, 8'h0, 1'b0);
    checkOutput("rw_out0_pre_reset", rw_out[31:0], 32'hDEADBEEF);
    #1 Rst_N = 1'b0;
    #1;
    checkOutput("async_reset_rw_out", rw_out, 0);
    checkOutput("async_reset_q", q, 0);
    checkOutput("async_reset_irq", irq, 0);
    #2 Rst_N = 1'b1;
    @(negedge Clk);
    readA(32'h80, 32'h0, 8'h0, 1'b0);
    readA(32'h00, 32'h0, 8'h0, 1'b0);
    readA(32'hC0, 32'h0, 8'h0, 1'b0);

    // Unmapped accesses
    readA(32'h100, 32'h0, 8'h0, 1'b1);
    writeA(32'h100, 32'hFFFF_FFFF, 4'b1111, 1'b1);
    readA(32'h84, 32'h0, 8'h0, 1'b1);
    readB(32'h100, 32'h0);
    readA(32'h00, 32'h0, 8'h0, 1'b0);
    @(negedge Clk);
    checkOutput("unmapped_rw_out", rw_out, 0);

    repeat (3) @(negedge Clk);
    checkOutput("scoreboard_drain", expA.size() + expB.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
